mau_result_collector: RTL
=========================

# mau_result_collector

Downstream drain stage for the four-lane matrix acceleration unit. Once a matrix operation has finished, it pulses `read_output` the required number of times and samples both 16-bit result buses on each beat. Samples are buffered in a small FIFO and presented to the GPU datapath as a valid/ready stream of 32-bit beats with a last marker. A read pulse is issued only when FIFO space for its sample is guaranteed.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 4..16.
- `RD_LATENCY`, 1: edges from `read_output` sampled high to bus data valid for capture; 1..3.

Ports:
- `clk`  input  1  the only clock in the block.
- `reset`  input  1  asynchronous, active-low.
- `collect`  input  1  start request; accepted only when `collect_ready` is high.
- `collect_beats`  input  4  number of read beats, latched on accept; 0 means 16.
- `collect_ready`  output  1  high in IDLE.
- `abort`  input  1  synchronous cancel of the current collection.
- `mau_any_busy`  input  1  OR of lane busy flags.
- `read_output`  output  1  read strobe to the MAU array; at most one pulse per cycle.
- `bus_owned`  output  1  high from READ entry until the last capture or abort; the arbiter keeps other drivers off both buses while it is high.
- `dbs_in`  input  16  superior data bus, sampled only.
- `dbi_in`  input  16  inferior data bus, sampled only.
- `res_valid`  output  1  FIFO head valid.
- `res_ready`  input  1  consumer accept.
- `res_data`  output  32  {dbi, dbs} of the head beat.
- `res_last`  output  1  head is the final beat of its collection.
- `done`  output  1  one-cycle pulse when the final beat is pushed into the FIFO.

## Operation
- States:
  - IDLE: `collect_ready` is high.
  - WAIT_IDLE: waiting for `mau_any_busy` low.
  - READ: issuing read beats.
  - DRAIN: waiting for in-flight captures to land.
- IDLE→WAIT_IDLE on `collect`. `collect_beats` is latched into `beats_left` (5-bit, 0 maps to 16).
- WAIT_IDLE→READ on the first cycle `mau_any_busy` is sampled low.
- READ: `read_output` is driven high when `beats_left`≠0 and `fifo_count + inflight < DEPTH`.
  - Each pulse decrements `beats_left` and increments `inflight`.
  - READ→DRAIN on the cycle the last pulse is issued.
- Capture pipeline: a shift register of depth `RD_LATENCY` carries a valid bit and a last bit for each pulse.
  - On exit from the pipeline, the bus pair is pushed into the FIFO and `inflight` is decremented.
  - The last bit is stored with the entry as `res_last`.
- DRAIN→IDLE when `inflight` reaches 0. `done` pulses in the same cycle the last beat is pushed.
- Credit rule: the FIFO never overflows. Any push attempted while full is an assertion failure.
- Pop: occurs when `res_valid && res_ready`. A push and pop in the same cycle leaves the count unchanged and is legal when full.
- `abort`, from any state:
  - The next state is IDLE and the capture pipeline is cleared.
  - FIFO entries from the aborted collection are discarded. `res_valid` is low the next cycle.
  - No `done` pulse is generated.
  - `abort` has priority over `collect` in the same cycle.
- `mau_any_busy` rising while in READ stalls further pulses until it falls. Pending captures still land.
- `collect` outside IDLE is ignored.

## Timing
- Reset values: state IDLE; FIFO and pipeline empty; `collect_ready`=1; all other outputs 0 (`res_data`=0).
- The `collect` accept edge to the first possible `read_output` takes 2 cycles, assuming `mau_any_busy` is low.
- Capture: a `read_output` pulse in cycle t is sampled at the edge ending cycle t+`RD_LATENCY`−1. `res_valid` is high in cycle t+`RD_LATENCY`.
- Peak throughput is 1 beat/cycle when `res_ready` is held high. With `res_ready` low, exactly `DEPTH` pulses are issued, then `read_output` stays low.
- `res_data` and `res_last` are stable while `res_valid && !res_ready`.

## Structure
- Package `mau_collect_pkg`:
  - `state_t` enum {IDLE, WAIT_IDLE, READ, DRAIN}
  - `MAU_BUS_W`=16
  - `BEAT_CNT_W`=5
  - `result_beat_t` struct {last, dbi, dbs}
- One sub-module, `result_fifo`: synchronous `DEPTH`-entry FIFO of `result_beat_t` with count output. Same clock and reset as the top.

## Test plan
- Reset is asserted mid-READ with 3 entries held: all outputs return to reset values asynchronously and `collect_ready`=1.
- `collect_beats`=8 with `res_ready`=1, `dbs_in`/`dbi_in` = beat index / index+0x100:
  - 8 consecutive `read_output` pulses occur.
  - 8 beats come out, from 0x0100_0000 through 0x0107_0007, with `res_last` on the 8th.
  - `done` pulses once.
- `collect_beats`=0, `res_ready`=0, `DEPTH`=8: exactly 8 pulses, then a stall. Raising `res_ready` completes all 16 beats in order.
- `mau_any_busy` is high for 20 cycles after `collect`: no `read_output` is issued until 2 cycles after it falls.
- `abort` is asserted after the 3rd pulse, with `RD_LATENCY`=2: the FIFO is empty the next cycle, no `done` occurs, and a new collection of 2 beats yields only its own 2 beats.
- Beats requested = 1 with `RD_LATENCY`=3: `res_valid` rises 3 cycles after the pulse, with `res_last`=1 and `done` in the same cycle as the push.

Source files
------------

// File: rtl/mau_collect_pkg.sv
// Shared types for the MAU result collector: FSM states, bus widths and the
// FIFO beat record.
package mau_collect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int MAU_BUS_W  = 16;
    localparam int BEAT_CNT_W = 5;

    typedef struct packed {
        logic                 last;
        logic [MAU_BUS_W-1:0] dbi;
        logic [MAU_BUS_W-1:0] dbs;
    } result_beat_t;

    // A request of zero beats means a full sixteen-beat drain.
    function automatic logic [BEAT_CNT_W-1:0] beats_decode(input logic [3:0] req);
        return (req == 4'd0) ? BEAT_CNT_W'(16) : {1'b0, req};
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of result beats with occupancy count and a flush that
// empties it in one cycle.
module result_fifo
    import mau_collect_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  result_beat_t           push_data_i,
    input  logic                   pop_i,
    output result_beat_t           head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    result_beat_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop, full;

    assign full    = (count_q == CW'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Credit accounting upstream must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (!reset)
        !(push_i && !flush_i && full && !do_pop));

endmodule

// File: rtl/mau_result_collector.sv
// Drain stage for the MAU array: issues credited read strobes, captures both
// result buses after the read latency and streams them out as 32-bit beats.
module mau_result_collector
    import mau_collect_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   collect,
    input  logic [3:0]             collect_beats,
    output logic                   collect_ready,
    input  logic                   abort,
    input  logic                   mau_any_busy,
    output logic                   read_output,
    output logic                   bus_owned,
    input  logic [MAU_BUS_W-1:0]   dbs_in,
    input  logic [MAU_BUS_W-1:0]   dbi_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*MAU_BUS_W-1:0] res_data,
    output logic                   res_last,
    output logic                   done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t                state_q, state_d;
    logic [BEAT_CNT_W-1:0] beats_left_q, beats_left_d;
    logic [BEAT_CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]      fifo_count;
    logic                  credit_ok, pulse_last;
    logic                  cap_vld, cap_last;
    logic                  push, pop;
    result_beat_t          push_beat, head_beat;

    // Entries already stored plus reads still in flight must leave room.
    assign credit_ok   = (6'(fifo_count) + 6'(inflight_q)) < 6'(DEPTH);
    assign pulse_last  = (beats_left_q == BEAT_CNT_W'(1));
    assign read_output = (state_q == READ) && (beats_left_q != '0) && credit_ok
                         && !mau_any_busy && !abort;

    assign collect_ready = (state_q == IDLE);
    assign bus_owned     = (state_q == READ) || (state_q == DRAIN);

    // With a latency of one the bus is captured on the strobe's own edge.
    if (RD_LATENCY == 1) begin : g_cap_direct
        assign cap_vld  = read_output;
        assign cap_last = pulse_last;
    end else begin : g_cap_pipe
        logic [RD_LATENCY-2:0] vld_q, last_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_q  <= '0;
                last_q <= '0;
            end else if (abort) begin
                vld_q  <= '0;
                last_q <= '0;
            end else begin
                vld_q[0]  <= read_output;
                last_q[0] <= pulse_last;
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    last_q[i] <= last_q[i-1];
                end
            end
        end

        assign cap_vld  = vld_q[RD_LATENCY-2];
        assign cap_last = last_q[RD_LATENCY-2];
    end

    assign push      = cap_vld && !abort;
    assign pop       = res_valid && res_ready;
    assign done      = push && cap_last;
    assign push_beat = '{last: cap_last, dbi: dbi_in, dbs: dbs_in};

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        inflight_d   = inflight_q;

        if (read_output) inflight_d = inflight_d + BEAT_CNT_W'(1);
        if (cap_vld)     inflight_d = inflight_d - BEAT_CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (collect) begin
                    beats_left_d = beats_decode(collect_beats);
                    state_d      = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!mau_any_busy) state_d = READ;
            end
            READ: begin
                if (read_output) begin
                    beats_left_d = beats_left_q - BEAT_CNT_W'(1);
                    if (pulse_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            beats_left_d = '0;
            inflight_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (abort),
        .push_i      (push),
        .push_data_i (push_beat),
        .pop_i       (pop),
        .head_o      (head_beat),
        .valid_o     (res_valid),
        .count_o     (fifo_count)
    );

    // The head slot may hold stale data when empty, so outputs are gated.
    assign res_data = res_valid ? {head_beat.dbi, head_beat.dbs} : '0;
    assign res_last = res_valid && head_beat.last;

endmodule
